gf180mcu_osu_sc_gp9t3v3__drv_seq: RTL and testbench
===================================================

GF180MCU_OSU_SC_GP9T3V3__DRV_SEQ -- requirements
Module: gf180mcu_osu_sc_gp9t3v3__drv_seq

Purpose: staggered-turn-on sequencer that drives the inputs of SEGS parallel high-drive inverter legs (inv_16), limiting di/dt on the shared output net.

Interface
REQ-001 The block SHALL have parameter SEGS, default 4, giving the number of inverter legs driven (legal range 2..16).
REQ-002 The block SHALL have parameter STEP, default 3, giving the number of idle cycles between consecutive leg flips (legal range 0..255).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 A  input  1  requested level on the shared inverter output net (1 = high).
REQ-007 EN  input  1  sequencing enable; 0 freezes all state.
REQ-008 LEG  output  SEGS  leg inputs; each bit feeds one inv_16 input, so that leg's output level = ~LEG[i].
REQ-009 BUSY  output  1  high while a sequence is in progress (state != IDLE).
REQ-010 DONE  output  1  one-cycle pulse when all legs reach the target.

Function
REQ-011 Target register T SHALL capture A on every rising edge when EN=1; T holds when EN=0.
REQ-012 Settled condition SHALL be LEG == {SEGS{~T}}; mismatch is any bit differing.
REQ-013 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-014 IDLE, EN=1, mismatch: at that edge, flip the lowest-index mismatched LEG bit, load the step counter with STEP, go to WAIT.
REQ-015 IDLE, settled or EN=0: no change.
REQ-016 WAIT, EN=1, counter != 0: decrement the counter; LEG unchanged.
REQ-017 WAIT, EN=1, counter == 0, mismatch: flip the lowest-index mismatched bit, reload STEP, stay in WAIT.
REQ-018 WAIT, EN=1, counter == 0, settled: go to IDLE and assert DONE for exactly that cycle.
REQ-019 At most one LEG bit SHALL change per cycle; consecutive flips SHALL be exactly STEP+1 cycles apart.
REQ-020 Latency: A changing before edge e SHALL produce the first LEG flip at edge e+1, from IDLE.
REQ-021 A reversal mid-sequence SHALL retarget the sequence without aborting it: flips continue toward the new T, lowest mismatched index first, with spacing preserved (no flip earlier than STEP+1 after the previous flip).
REQ-022 A glitch on A that returns to its original value before any flip SHALL cause no LEG change, but WAIT/DONE still apply if a flip already occurred.
REQ-023 STEP=0 SHALL flip one leg per cycle; a full transition takes SEGS cycles, with DONE one cycle after the last flip.
REQ-024 EN=0 SHALL freeze state, counter, T, and LEG; DONE SHALL be 0 while EN=0.
REQ-025 BUSY and DONE SHALL be registered outputs (no combinational path from A or EN).

Reset
REQ-026 On RST=1 at a rising edge: LEG = all ones (all leg outputs low), T=0, counter=0, state=IDLE, BUSY=0, DONE=0.
REQ-027 RST SHALL take priority over EN and any in-progress sequence; an abrupt return of LEG to all ones is accepted behaviour.
REQ-028 After release of RST with A=0, the block SHALL remain settled and idle.

Structure
REQ-029 Package gf180mcu_osu_sc_gp9t3v3__drv_seq_pkg SHALL hold the state enum (IDLE, WAIT), the default SEGS/STEP constants, and the counter width constant (8).
REQ-030 The step counter SHALL be a sub-module, gf180mcu_osu_sc_gp9t3v3__drv_seq_tmr (load, decrement, hold, zero flag).
REQ-031 Lowest-mismatch selection SHALL be a combinational priority encoder inside the top module.

Verification
REQ-032 Defaults, reset, then A 0->1 held: LEG bits clear in order 0,1,2,3 at cycles +1,+5,+9,+13 after A is sampled; DONE at +17; BUSY high from +1 through +16.
REQ-033 A 0->1, then A->0 after the second flip: LEG returns 1100->1101->1111 (bit order 3..0), flips stay 4 cycles apart, exactly one DONE.
REQ-034 STEP=0, SEGS=8, A 0->1: LEG clears one bit per cycle over 8 cycles; DONE on cycle 9.
REQ-035 EN=0 asserted for 10 cycles mid-WAIT: LEG, counter, and BUSY are frozen; sequence resumes with the remaining count intact.
REQ-036 RST asserted with LEG=1100: next edge gives LEG=1111, BUSY=0, DONE=0; no further flips with A=0.
REQ-037 Assertion checked throughout: popcount(LEG ^ LEG_prev) <= 1 every cycle, and DONE never on two consecutive cycles.

Source files
------------

// File: rtl/gf180mcu_osu_sc_gp9t3v3__drv_seq_pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_osu_sc_gp9t3v3__drv_seq_pkg
// Shared types and constants for the staggered inverter-leg drive sequencer.
//   state_e      : sequencer FSM states (IDLE, WAIT)
//   SEGS_DEF     : default number of inverter legs
//   STEP_DEF     : default number of idle cycles between consecutive leg flips
//   CNT_W        : width of the inter-flip step counter
// -----------------------------------------------------------------------------
package gf180mcu_osu_sc_gp9t3v3__drv_seq_pkg;

   localparam int unsigned SEGS_DEF = 4;
   localparam int unsigned STEP_DEF = 3;
   localparam int          CNT_W    = 8;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

endpackage : gf180mcu_osu_sc_gp9t3v3__drv_seq_pkg

// File: rtl/gf180mcu_osu_sc_gp9t3v3__drv_seq_tmr.sv
// -----------------------------------------------------------------------------
// gf180mcu_osu_sc_gp9t3v3__drv_seq_tmr
// Step counter that spaces consecutive leg flips. Load has priority over
// decrement; with neither asserted the count holds.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i into the counter
//   dec_i      : decrement the counter by one
//   load_val_i : value loaded on load_i
//   zero_o     : counter currently equals zero
// -----------------------------------------------------------------------------
module gf180mcu_osu_sc_gp9t3v3__drv_seq_tmr
   import gf180mcu_osu_sc_gp9t3v3__drv_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: the hold value is assigned first so every path drives cnt_d; no latch.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   // NOTE: this is a single register, not a memory, so it is reset explicitly.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule : gf180mcu_osu_sc_gp9t3v3__drv_seq_tmr

// File: rtl/gf180mcu_osu_sc_gp9t3v3__drv_seq.sv
// -----------------------------------------------------------------------------
// gf180mcu_osu_sc_gp9t3v3__drv_seq
// Staggered turn-on sequencer for SEGS parallel inv_16 legs sharing one output
// net. A requested level change is applied one leg at a time, lowest index
// first, with STEP idle cycles between flips to limit di/dt on the shared net.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset (all legs driven high -> output low)
//   A    : requested level of the shared output net (1 = high)
//   EN   : sequencing enable; 0 freezes all state
//   LEG  : leg inputs, leg output level = ~LEG[i]
//   BUSY : a sequence is in progress (registered)
//   DONE : one-cycle pulse when all legs have reached the target (registered)
// -----------------------------------------------------------------------------
module gf180mcu_osu_sc_gp9t3v3__drv_seq
   import gf180mcu_osu_sc_gp9t3v3__drv_seq_pkg::*;
#(
   parameter int unsigned SEGS = SEGS_DEF,
   parameter int unsigned STEP = STEP_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            A,
   input  logic            EN,
   output logic [SEGS-1:0] LEG,
   output logic            BUSY,
   output logic            DONE
);

   localparam logic [CNT_W-1:0] STEP_VAL = CNT_W'(STEP);

   state_e          state_q, state_d;
   logic            t_q, t_d;
   logic [SEGS-1:0] leg_q, leg_d;
   logic            done_q, done_d;

   logic [SEGS-1:0] mismatch_vec;
   logic            mismatch;
   logic [SEGS-1:0] flip_mask;
   logic            pe_found;

   logic            tmr_load;
   logic            tmr_dec;
   logic            tmr_zero;

   // Legs are settled when every leg input is the inverse of the target level.
   assign mismatch_vec = leg_q ^ {SEGS{~t_q}};
   assign mismatch     = |mismatch_vec;

   // Priority encoder: one-hot mask of the lowest-index mismatched leg, so at
   // most one leg can change per flip.
   always_comb begin
      flip_mask = '0;
      pe_found  = 1'b0;
      for (int i = 0; i < int'(SEGS); i++) begin
         if (mismatch_vec[i] && !pe_found) begin
            flip_mask[i] = 1'b1;
            pe_found     = 1'b1;
         end
      end
   end

   // Next-state logic. Mismatch is evaluated against the registered target, so
   // a change on A reaches the legs one edge after it is captured, and a
   // reversal mid-sequence simply redirects the next flip.
   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      leg_d    = leg_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;

      if (EN) begin
         t_d = A;
         unique case (state_q)
            IDLE: begin
               if (mismatch) begin
                  leg_d    = leg_q ^ flip_mask;
                  tmr_load = 1'b1;
                  state_d  = WAIT;
               end
            end
            WAIT: begin
               if (!tmr_zero) begin
                  tmr_dec = 1'b1;
               end else if (mismatch) begin
                  leg_d    = leg_q ^ flip_mask;
                  tmr_load = 1'b1;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         t_q     <= 1'b0;
         leg_q   <= '1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         leg_q   <= leg_d;
         done_q  <= done_d;
      end
   end

   gf180mcu_osu_sc_gp9t3v3__drv_seq_tmr u_tmr (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (tmr_load),
      .dec_i      (tmr_dec),
      .load_val_i (STEP_VAL),
      .zero_o     (tmr_zero)
   );

   assign LEG  = leg_q;
   assign BUSY = (state_q == WAIT);
   assign DONE = done_q;

endmodule : gf180mcu_osu_sc_gp9t3v3__drv_seq

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__drv_seq.sv
// -----------------------------------------------------------------------------
// Testbench for gf180mcu_osu_sc_gp9t3v3__drv_seq.
// dut0: default SEGS=4, STEP=3.  dut1: SEGS=8, STEP=0.
// Stimulus pushes hand-computed expected output events (LEG change or DONE
// pulse, with the cycle it must appear on) into a queue per DUT; a monitor
// samples on the falling edge and pops/compares whenever an event occurs.
// -----------------------------------------------------------------------------
module tb_gf180mcu_osu_sc_gp9t3v3__drv_seq;

   typedef struct {
      int         cyc;
      logic [7:0] leg;
      logic       done;
      logic       busy;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       a0, en0, a1, en1;
   logic [3:0] leg0;
   logic [7:0] leg1;
   logic       busy0, done0, busy1, done1;

   int   cyc      = 0;
   logic rst_edge = 1'b1;
   bit   mon_on   = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   ev_t  exp_q0[$];
   ev_t  exp_q1[$];

   gf180mcu_osu_sc_gp9t3v3__drv_seq #(.SEGS(4), .STEP(3)) dut0 (
      .CLK(clk), .RST(rst), .A(a0), .EN(en0),
      .LEG(leg0), .BUSY(busy0), .DONE(done0)
   );

   gf180mcu_osu_sc_gp9t3v3__drv_seq #(.SEGS(8), .STEP(0)) dut1 (
      .CLK(clk), .RST(rst), .A(a1), .EN(en1),
      .LEG(leg1), .BUSY(busy1), .DONE(done1)
   );

   always #5 clk = ~clk;

   // Edge counter: after rising edge n, cyc == n until the next rising edge.
   always @(posedge clk) begin
      cyc++;
      rst_edge = rst;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int id, input int c, input logic [7:0] leg,
                       input logic done, input logic busy);
      ev_t ev;
      ev.cyc  = c;
      ev.leg  = leg;
      ev.done = done;
      ev.busy = busy;
      if (id == 0) exp_q0.push_back(ev);
      else         exp_q1.push_back(ev);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic observe(input int id, input logic [7:0] leg, input logic [7:0] prev,
                          input logic done, input logic dprev, input logic busy);
      ev_t ev;
      bit  have;
      if (!rst_edge) check($sformatf("dut%0d_one_flip", id), 32'($countones(leg ^ prev) <= 1), 1);
      check($sformatf("dut%0d_done_pair", id), 32'(done & dprev), 0);
      if ((leg != prev) || done) begin
         have = (id == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
         check($sformatf("dut%0d_event_expected", id), 32'(have), 1);
         if (have) begin
            if (id == 0) ev = exp_q0.pop_front();
            else         ev = exp_q1.pop_front();
            check($sformatf("dut%0d_evt_cycle", id), cyc, ev.cyc);
            check($sformatf("dut%0d_evt_leg", id), 32'(leg), 32'(ev.leg));
            check($sformatf("dut%0d_evt_done", id), 32'(done), 32'(ev.done));
            check($sformatf("dut%0d_evt_busy", id), 32'(busy), 32'(ev.busy));
         end
      end
   endtask

   // Monitor: decoupled from stimulus, compares whenever an output event occurs.
   initial begin
      logic [7:0] prev0, prev1;
      logic       dprev0, dprev1;
      prev0  = '0;
      prev1  = '0;
      dprev0 = 1'b0;
      dprev1 = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            observe(0, {4'h0, leg0}, prev0, done0, dprev0, busy0);
            observe(1, leg1, prev1, done1, dprev1, busy1);
         end
         prev0  = {4'h0, leg0};
         prev1  = leg1;
         dprev0 = done0;
         dprev1 = done1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e;
      logic [7:0] fast_leg [8];
      fast_leg = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

      rst = 1'b1; a0 = 1'b0; en0 = 1'b1; a1 = 1'b0; en1 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state.
      check("rst_leg0", 32'(leg0), 32'h0F);
      check("rst_busy0", 32'(busy0), 0);
      check("rst_done0", 32'(done0), 0);
      check("rst_leg1", 32'(leg1), 32'hFF);
      check("rst_busy1", 32'(busy1), 0);
      mon_on = 1'b1;

      // Idle after reset with A=0: no events expected.
      repeat (6) @(negedge clk);

      // A 0->1 held: bits clear 0,1,2,3 at +1,+5,+9,+13, DONE at +17.
      e = cyc + 1; a0 = 1'b1;
      push(0, e + 1,  8'h0E, 0, 1);
      push(0, e + 5,  8'h0C, 0, 1);
      push(0, e + 9,  8'h08, 0, 1);
      push(0, e + 13, 8'h00, 0, 1);
      push(0, e + 17, 8'h00, 1, 0);
      wait_cyc(e + 20);

      // A 1->0 held: legs return to all ones, lowest index first.
      e = cyc + 1; a0 = 1'b0;
      push(0, e + 1,  8'h01, 0, 1);
      push(0, e + 5,  8'h03, 0, 1);
      push(0, e + 9,  8'h07, 0, 1);
      push(0, e + 13, 8'h0F, 0, 1);
      push(0, e + 17, 8'h0F, 1, 0);
      wait_cyc(e + 20);

      // Reversal after the second flip: 1100 -> 1101 -> 1111, one DONE.
      e = cyc + 1; a0 = 1'b1;
      push(0, e + 1,  8'h0E, 0, 1);
      push(0, e + 5,  8'h0C, 0, 1);
      push(0, e + 9,  8'h0D, 0, 1);
      push(0, e + 13, 8'h0F, 0, 1);
      push(0, e + 17, 8'h0F, 1, 0);
      wait_cyc(e + 5); a0 = 1'b0;
      wait_cyc(e + 20);

      // One-cycle glitch on A: captured target already flipped bit 0, so the
      // sequence undoes it and still ends with DONE.
      e = cyc + 1; a0 = 1'b1;
      push(0, e + 1, 8'h0E, 0, 1);
      push(0, e + 5, 8'h0F, 0, 1);
      push(0, e + 9, 8'h0F, 1, 0);
      wait_cyc(e); a0 = 1'b0;
      wait_cyc(e + 12);

      // RST with LEG=1100: abrupt return to 1111, then idle with A=0.
      e = cyc + 1; a0 = 1'b1;
      push(0, e + 1, 8'h0E, 0, 1);
      push(0, e + 5, 8'h0C, 0, 1);
      push(0, e + 6, 8'h0F, 0, 0);
      wait_cyc(e + 5); rst = 1'b1; a0 = 1'b0;
      wait_cyc(e + 6); rst = 1'b0;
      wait_cyc(e + 16);

      // EN=0 for 10 cycles mid-WAIT: everything frozen (A changes ignored),
      // then the remaining count of 2 resumes.
      e = cyc + 1; a0 = 1'b1;
      push(0, e + 1,  8'h0E, 0, 1);
      push(0, e + 15, 8'h0C, 0, 1);
      push(0, e + 19, 8'h08, 0, 1);
      push(0, e + 23, 8'h00, 0, 1);
      push(0, e + 27, 8'h00, 1, 0);
      wait_cyc(e + 2); en0 = 1'b0;
      for (int c = e + 3; c <= e + 12; c++) begin
         wait_cyc(c);
         check("frozen_busy0", 32'(busy0), 1);
         if (c == e + 3) a0 = 1'b0;
      end
      a0 = 1'b1; en0 = 1'b1;
      wait_cyc(e + 30);

      // SEGS=8, STEP=0: one leg per cycle over 8 cycles, DONE on cycle 9.
      e = cyc + 1; a1 = 1'b1;
      for (int k = 0; k < 8; k++) push(1, e + 1 + k, fast_leg[k], 0, 1);
      push(1, e + 9, 8'h00, 1, 0);
      wait_cyc(e + 14);

      check("pending_events0", exp_q0.size(), 0);
      check("pending_events1", exp_q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_gf180mcu_osu_sc_gp9t3v3__drv_seq
